// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and default sizes for the FIFO write arbiter
// Contents:
//   state_t   - arbiter FSM states (ST_IDLE=0, ST_BURST=1)
//   NREQ_DEF  - default number of requesters
//   DW_DEF    - default data width (must match the FIFO)
//   LW_DEF    - default burst length field width
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 32;
    localparam int LW_DEF   = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
// Ports:
//   req  - request vector
//   last - index of the most recently served requester
//   pick - one-hot winner, searching from last+1 modulo NREQ
//   any  - at least one request is present
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         pick,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Walk the ring starting just after the last winner; the first hit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (req[idx] && pick == '0) pick[idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async FIFO write port
// Ports:
//   clk, reset_n            - write-side clock, asynchronous active-low reset
//   req_valid/len/data      - per-requester burst request, length-1, data word
//   req_ready               - per-requester word accepted this cycle
//   grant, busy             - one-hot burst owner, high while a burst is active
//   fifo_wr_en/wr_data      - FIFO write side
//   fifo_full, fifo_afull   - FIFO status inputs
// Optional: define FIFO_ARB_AFULL_THROTTLE_EN to suppress new grants while
// fifo_afull is high; otherwise fifo_afull is ignored.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*LW-1:0] req_len,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              fifo_wr_en,
    output logic [DW-1:0]     fifo_wr_data,
    input  logic              fifo_full,
    input  logic              fifo_afull
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n, pick, req_sel;
    logic [IW-1:0]   last, last_n, gidx;
    logic [LW-1:0]   cnt, cnt_n, len_sel;
    logic [DW-1:0]   data_sel;
    logic            any;

`ifdef FIFO_ARB_AFULL_THROTTLE_EN
    // Only new selections are throttled; an active burst ignores afull.
    assign req_sel = fifo_afull ? '0 : req_valid;
`else
    logic unused_afull;
    assign unused_afull = fifo_afull;
    assign req_sel      = req_valid;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req_sel),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    // Owner data/index come from the registered grant; length from the fresh pick.
    always_comb begin
        gidx     = '0;
        data_sel = '0;
        len_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx     = IW'(i);
                data_sel = req_data[i*DW +: DW];
            end
            if (pick[i]) len_sel = req_len[i*LW +: LW];
        end
    end

    assign busy         = state == ST_BURST;
    assign fifo_wr_en   = busy & |(req_valid & grant) & ~fifo_full;
    assign req_ready    = (busy & ~fifo_full) ? grant : '0;
    assign fifo_wr_data = data_sel;

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        cnt_n   = cnt;
        if (state == ST_IDLE) begin
            if (any) begin
                state_n = ST_BURST;
                grant_n = pick;
                cnt_n   = len_sel;
            end
        end else if (fifo_wr_en) begin
            if (cnt == '0) begin
                state_n = ST_IDLE;
                grant_n = '0;
                last_n  = gidx;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (table vectors plus write scoreboard)
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LW   = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid, req_ready, grant;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*DW-1:0] req_data;
    logic              busy, fifo_wr_en, fifo_full, fifo_afull;
    logic [DW-1:0]     fifo_wr_data;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_len      (req_len),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] v;
        logic            f;
        logic [31:0]     len;
        logic [NREQ-1:0] g;
        logic            wr;
        logic [NREQ-1:0] rdy;
    } vec_t;

    typedef struct {
        int r;
        int k;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   idx[NREQ];
    logic [NREQ-1:0] acc;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic logic [31:0] pat(int r, int k);
        return 32'(32'hA500_0000 + r * 65536 + k);
    endfunction

    always_comb
        for (int r = 0; r < NREQ; r++) req_data[r*DW +: DW] = pat(r, idx[r]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input int n, input logic rst, input logic [3:0] v, input logic f,
                       input logic [31:0] len, input logic [3:0] g, input logic wr, input logic [3:0] rdy);
        for (int i = 0; i < n; i++)
            tbl.push_back('{rst: rst && i == 0, v: v, f: f, len: len, g: g, wr: wr, rdy: rdy});
    endtask

    task automatic expect_burst(input int r, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) sbq.push_back('{r: r, k: k});
    endtask

    task automatic wait_idx(input int r, input int n, input int lim, input string name);
        int c = 0;
        while (idx[r] < n && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, idx[r], n);
    endtask

    task automatic rst_seq();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Write monitor: every FIFO write is matched against the expected stream.
    always @(negedge clk) begin
        acc = reset_n ? (req_valid & req_ready) : '0;
        if (reset_n && fifo_wr_en) begin
            chk("wr_while_full", fifo_full, 1'b0);
            if (sbq.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: data %0h with empty scoreboard", fifo_wr_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("wr_data r%0d k%0d", e.r, e.k), fifo_wr_data, pat(e.r, e.k));
            end
        end
    end

    // Requester model: advance to the next word after a handshake.
    always @(posedge clk)
        for (int r = 0; r < NREQ; r++) idx[r] <= reset_n ? idx[r] + int'(acc[r]) : 0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_len    = '0;
        fifo_full  = 1'b0;
`ifdef FIFO_ARB_AFULL_THROTTLE_EN
        fifo_afull = 1'b0;
`else
        fifo_afull = 1'b1;
`endif
        // Single burst, len=3
        add(1, 1, 4'b0001, 0, 32'h0000_0003, 4'b0000, 0, 4'b0000);
        add(4, 0, 4'b0001, 0, 32'h0000_0003, 4'b0001, 1, 4'b0001);
        add(2, 0, 4'b0000, 0, 32'h0000_0003, 4'b0000, 0, 4'b0000);
        expect_burst(0, 0, 4);
        // Round-robin, all valid, len=0
        add(1, 1, 4'b1111, 0, 32'h0, 4'b0000, 0, 4'b0000);
        for (int b = 0; b < 5; b++) begin
            add(1, 0, 4'b1111, 0, 32'h0, 4'b0001 << (b % 4), 1, 4'b0001 << (b % 4));
            add(1, 0, b == 4 ? 4'b0000 : 4'b1111, 0, 32'h0, 4'b0000, 0, 4'b0000);
        end
        expect_burst(0, 0, 1);
        expect_burst(1, 0, 1);
        expect_burst(2, 0, 1);
        expect_burst(3, 0, 1);
        expect_burst(0, 1, 1);
        // Backpressure on req 1, len=7; len changes mid-burst are ignored
        add(1, 1, 4'b0010, 0, 32'h0000_0700, 4'b0000, 0, 4'b0000);
        add(3, 0, 4'b0010, 0, 32'h0000_0700, 4'b0010, 1, 4'b0010);
        add(5, 0, 4'b0010, 1, 32'h0000_0100, 4'b0010, 0, 4'b0000);
        add(5, 0, 4'b0010, 0, 32'h0000_0100, 4'b0010, 1, 4'b0010);
        add(1, 0, 4'b0000, 0, 32'h0000_0100, 4'b0000, 0, 4'b0000);
        expect_burst(1, 0, 8);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (tbl[i].rst) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk($sformatf("reset_state row%0d", i), {grant, busy, fifo_wr_en, req_ready}, 10'h0);
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
            req_valid = tbl[i].v;
            fifo_full = tbl[i].f;
            req_len   = tbl[i].len;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {grant, busy, fifo_wr_en, req_ready},
                {tbl[i].g, |tbl[i].g, tbl[i].wr, tbl[i].rdy});
        end
        chk("table_sb_drained", sbq.size(), 0);
        fifo_afull = 1'b0;

        // Requester stall: req 2 drops valid mid-burst, req 3 waits
        rst_seq();
        req_len = 32'h0005_0000;
        expect_burst(2, 0, 6);
        expect_burst(3, 0, 1);
        req_valid = 4'b1100;
        wait_idx(2, 2, 20, "stall_pre");
        req_valid = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {grant, fifo_wr_en}, {4'b0100, 1'b0});
            @(posedge clk);
            #1;
        end
        req_valid = 4'b1100;
        wait_idx(2, 6, 20, "stall_r2_done");
        req_valid = 4'b1000;
        @(negedge clk);
        chk("stall_bubble", {grant, busy}, 5'h0);
        @(posedge clk);
        #1;
        wait_idx(3, 1, 10, "stall_r3_done");
        req_valid = 4'b0000;
        @(negedge clk);
        chk("stall_idle", {grant, busy}, 5'h0);
        chk("stall_sb_drained", sbq.size(), 0);

        // Maximum length burst: 256 words, then idle
        rst_seq();
        req_len = 32'h0000_00FF;
        expect_burst(0, 0, 256);
        req_valid = 4'b0001;
        wait_idx(0, 256, 300, "max_len_words");
        req_valid = 4'b0000;
        @(negedge clk);
        chk("max_len_idle", {grant, busy}, 5'h0);
        chk("max_len_sb_drained", sbq.size(), 0);

        // Reset mid-burst while last pointer is not at its reset value
        rst_seq();
        req_len = 32'h0009_0000;
        expect_burst(1, 0, 1);
        req_valid = 4'b0010;
        wait_idx(1, 1, 10, "rst_pre_r1");
        expect_burst(2, 0, 10);
        req_valid = 4'b0100;
        wait_idx(2, 3, 10, "rst_pre_r2");
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {grant, busy, fifo_wr_en, req_ready}, 10'h0);
        sbq.delete();
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        req_len   = 32'h0;
        reset_n   = 1'b1;
        expect_burst(0, 0, 1);
        @(negedge clk);
        chk("rst_release_idle", grant, 4'b0000);
        @(negedge clk);
        chk("rst_priority_r0", grant, 4'b0001);
        @(posedge clk);
        #1 req_valid = 4'b0000;
        chk("rst_r0_word", idx[0], 1);
        chk("rst_sb_drained", sbq.size(), 0);

`ifdef FIFO_ARB_AFULL_THROTTLE_EN
        // Throttle: no grant while afull; afull mid-burst has no effect
        rst_seq();
        fifo_afull = 1'b1;
        req_len    = 32'h0000_0002;
        expect_burst(0, 0, 3);
        req_valid  = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            chk("afull_hold", {grant, busy}, 5'h0);
            @(posedge clk);
            #1;
        end
        fifo_afull = 1'b0;
        @(negedge clk);
        chk("afull_select_cycle", grant, 4'b0000);
        @(negedge clk);
        chk("afull_grant", grant, 4'b0001);
        @(posedge clk);
        #1 fifo_afull = 1'b1;
        wait_idx(0, 3, 10, "afull_burst_done");
        req_valid = 4'b0000;
        @(negedge clk);
        chk("afull_idle", {grant, busy}, 5'h0);
        chk("afull_sb_drained", sbq.size(), 0);
        fifo_afull = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one async_fifo instance between NREQ requesters, all in the write-clock domain.
- Each requester presents a burst (length plus data stream). The arbiter grants one requester at a time in round-robin order and streams the whole burst into the FIFO, stalling on full.
- Sits directly in front of the FIFO write side. Its fifo_* ports connect to the FIFO's wr_en, wr_data, full and afull.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, data width; must equal the FIFO's DW
- LW, 8, burst length field width; burst length is req_len+1 words (1..2^LW)

Ports:
- clk  in  1  write-side clock, same as the FIFO's wr_clk
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester: burst pending / data word valid
- req_len  in  NREQ*LW  per-requester burst length minus 1; slice i = [i*LW +: LW]
- req_data  in  NREQ*DW  per-requester data; slice i = [i*DW +: DW]
- req_ready  out  NREQ  per-requester: data word accepted this cycle
- grant  out  NREQ  one-hot owner of the current burst; all zero when idle
- busy  out  1  high while in BURST
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DW  FIFO write data
- fifo_full  in  1  FIFO full (combinational full)
- fifo_afull  in  1  FIFO almost-full

Behaviour:
- Reset values: grant=0, busy=0, req_ready=0, fifo_wr_en=0. State=IDLE, last-grant pointer=NREQ-1 (so requester 0 has highest priority first), beat counter=0.
- Two states, IDLE and BURST.
- IDLE:
  - If any req_valid is high, select the first requester with req_valid set, searching from last+1 modulo NREQ.
  - On the next clock: register grant (one-hot), load the counter with that requester's req_len, enter BURST.
  - No grant and no write occur in the same cycle as the selection.
- BURST, owner g:
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_wr_data = req_data slice g, passed through combinationally. Latency from request data to FIFO is 0 cycles once granted.
- Each accepted word (fifo_wr_en high) decrements the counter.
- Burst end:
  - When a word is accepted with counter==0, go to IDLE next clock, clear grant, set last=g.
  - This gives exactly one bubble cycle between bursts.
- req_valid[g] low mid-burst: stall. Grant is held and the burst is never abandoned or pre-empted.
- fifo_full high: no write and no ready. The counter holds until the FIFO drains.
- req_len is sampled only at grant time. Later changes are ignored until the next grant.
- Wrap-around: req_len = 2^LW-1 gives a 2^LW-word burst and the counter does not underflow. The pointer wraps from NREQ-1 to 0.
- Simultaneous requests: strict round-robin rotation. With all requesters active, bursts are granted 0,1,2,3,0,...
- A lone requester re-requesting is granted again after the bubble cycle.
- fifo_wr_en is never high when fifo_full is high, and never high outside BURST.
- Reset mid-burst: immediately returns to reset values. The partial burst is dropped (words already written remain in the FIFO).

Optional Feature:
- Macro FIFO_ARB_AFULL_THROTTLE_EN.
- Defined: IDLE does not select or grant while fifo_afull is high. Selection resumes on the first cycle afull is low. An in-progress burst is unaffected by afull.
- Undefined: fifo_afull is ignored (port still present, unused). Grants depend only on req_valid.

Decomposition:
- Package fifo_arb_pkg: state encoding constants (ST_IDLE=0, ST_BURST=1) and the default NREQ/DW/LW localparams.
- One sub-module, rr_pick:
  - Combinational round-robin picker, parameter NREQ.
  - Inputs: request vector, last index. Outputs: one-hot pick, any-request flag.
  - Reused by later arbiters.

Test Plan:
- Single burst: req 0 valid, len=3, FIFO never full -> grant=0001 one cycle after valid; fifo_wr_en high 4 consecutive cycles with data D0..D3; then grant=0, busy=0.
- Round-robin: all 4 valid, len=0 each -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle between bursts; one write per burst.
- Backpressure: req 1 granted, len=7; force fifo_full high for 5 cycles after 3rd word -> no fifo_wr_en and req_ready[1]=0 during full; exactly 8 words total, order preserved.
- Requester stall: req 2 drops valid for 3 cycles mid-burst while req 3 is valid -> grant stays 0100; req 3 granted only after req 2's last word.
- Max length and reset: len=255 -> 256 writes, counter ends at 0; separately assert reset_n low mid-burst -> all outputs 0 next sample; after release, req 0 has priority.
- With FIFO_ARB_AFULL_THROTTLE_EN: afull high while idle with req 0 valid -> no grant until afull low; afull rising mid-burst -> burst completes.
